// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
// Single-cycle hits, word-by-word line refill from a backing memory port.
module icache #(
    parameter int RW         = 16,
    parameter int I_SIZE     = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [RW-1:0]     i_req_addr,
    input  logic              i_req_submit,
    output logic              o_req_ack,
    output logic [I_SIZE-1:0] o_req_data,
    output logic              o_mem_req,
    output logic [RW-1:0]     o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [I_SIZE-1:0] i_mem_data,
    input  logic              i_invalidate,
    output logic              o_dbg_miss
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = RW - IDX - OFF;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t state, state_nxt;

    logic [RW-1:0]     addr;
    logic [OFF-1:0]    beat;
    logic              stale;
    logic [LINES-1:0]  valid;
    logic [TAG-1:0]    tags [LINES];
    logic [I_SIZE-1:0] data [LINES*LINE_WORDS];

    logic [TAG-1:0] a_tag;
    logic [IDX-1:0] a_idx;
    logic [OFF-1:0] a_off;
    logic           hit;
    logic           last;
    logic           accept;
    logic           fill;

    assign a_tag = addr[RW-1:OFF+IDX];
    assign a_idx = addr[OFF+IDX-1:OFF];
    assign a_off = addr[OFF-1:0];
    assign hit   = valid[a_idx] && (tags[a_idx] == a_tag) && !i_invalidate;
    assign last  = (beat == OFF'(LINE_WORDS-1));
    assign fill  = (state == REFILL) && i_mem_ack;

    always_comb begin
        state_nxt  = state;
        o_req_ack  = 1'b0;
        o_req_data = '0;
        o_mem_req  = 1'b0;
        o_dbg_miss = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req_submit) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    o_req_ack  = 1'b1;
                    o_req_data = data[{a_idx, a_off}];
                    accept     = i_req_submit;
                    state_nxt  = i_req_submit ? LOOKUP : IDLE;
                end else begin
                    o_dbg_miss = 1'b1;
                    state_nxt  = REFILL;
                end
            end
            REFILL: begin
                o_mem_req = 1'b1;
                if (i_mem_ack && last)
                    state_nxt = LOOKUP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            beat       <= '0;
            stale      <= 1'b0;
            valid      <= '0;
            o_mem_addr <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                addr <= i_req_addr;
            if (o_dbg_miss) begin
                o_mem_addr <= {a_tag, a_idx, {OFF{1'b0}}};
                beat       <= '0;
                stale      <= 1'b0;
            end
            // beat wraps inside the line so the address never leaves it
            if (fill) begin
                beat       <= beat + 1'b1;
                o_mem_addr <= {o_mem_addr[RW-1:OFF], beat + 1'b1};
            end
            if (state == REFILL && i_invalidate)
                stale <= 1'b1;
            if (i_invalidate)
                valid <= '0;
            else if (fill && last && !stale)
                valid[a_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (fill) begin
            data[{a_idx, beat}] <= i_mem_data;
            if (last)
                tags[a_idx] <= a_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: miss/hit timing, eviction,
// invalidate during refill, reset during refill, top line.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_addr = '0;
    logic        req_submit = 1'b0;
    logic        req_ack;
    logic [31:0] req_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        invalidate = 1'b0;
    logic        dbg_miss;

    int vectors = 0;
    int miscompares = 0;
    int mem_acks = 0;
    int misses = 0;
    logic stray = 1'b0;

    icache dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_addr  (req_addr),
        .i_req_submit(req_submit),
        .o_req_ack   (req_ack),
        .o_req_data  (req_data),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .i_mem_ack   (mem_ack),
        .i_mem_data  (mem_data),
        .i_invalidate(invalidate),
        .o_dbg_miss  (dbg_miss)
    );

    always #5 clk = ~clk;

    // zero-wait backing memory: word at address a is 0xA0 + a
    always @(negedge clk) begin
        mem_ack  = mem_req | stray;
        mem_data = 32'hA0 + 32'(mem_addr);
    end

    always @(posedge clk) begin
        if (mem_ack && mem_req) mem_acks++;
        if (dbg_miss) misses++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic sub, input logic [15:0] a,
                         input logic inv);
        @(negedge clk);
        req_submit = sub;
        req_addr   = a;
        invalidate = inv;
        #1;
    endtask

    task automatic run_req(input string tag, input logic [15:0] a,
                           input logic [31:0] exp, input int lat);
        int n = 0;
        cycle(1'b1, a, 1'b0);
        do begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end while (!req_ack && n < 60);
        chk({tag, " lat"}, 32'(n), 32'(lat));
        chk({tag, " data"}, req_data, exp);
    endtask

    initial begin
        int m0;
        int a0;
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cycle(1'b0, '0, 1'b0);
        chk("rst ack", 32'(req_ack), 0);
        chk("rst data", req_data, 0);
        chk("rst mreq", 32'(mem_req), 0);
        chk("rst maddr", 32'(mem_addr), 0);
        chk("rst miss", 32'(dbg_miss), 0);
        cycle(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);

        // cold miss with exact cycle timing
        cycle(1'b1, 16'h0000, 1'b0);
        chk("cold ack C", 32'(req_ack), 0);
        cycle(1'b0, '0, 1'b0);
        chk("cold miss", 32'(dbg_miss), 1);
        chk("cold mreq C+1", 32'(mem_req), 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk($sformatf("cold mreq %0d", i), 32'(mem_req), 1);
            chk($sformatf("cold maddr %0d", i), 32'(mem_addr), 32'(i));
        end
        cycle(1'b1, 16'h0001, 1'b0);
        chk("cold ack", 32'(req_ack), 1);
        chk("cold data", req_data, 32'hA0);
        chk("cold mreq end", 32'(mem_req), 0);

        // streaming hits
        cycle(1'b1, 16'h0002, 1'b0);
        chk("hit1 ack", 32'(req_ack), 1);
        chk("hit1 data", req_data, 32'hA1);
        cycle(1'b1, 16'h0003, 1'b0);
        chk("hit2 ack", 32'(req_ack), 1);
        chk("hit2 data", req_data, 32'hA2);
        cycle(1'b0, '0, 1'b0);
        chk("hit3 ack", 32'(req_ack), 1);
        chk("hit3 data", req_data, 32'hA3);
        chk("hit3 mreq", 32'(mem_req), 0);
        cycle(1'b0, '0, 1'b0);
        chk("idle ack", 32'(req_ack), 0);
        chk("stream acks", 32'(mem_acks), 4);
        chk("stream misses", 32'(misses), 1);

        // conflict eviction on index 0
        m0 = misses;
        run_req("evict", 16'h0040, 32'hE0, 6);
        run_req("reload", 16'h0000, 32'hA0, 6);
        chk("evict misses", 32'(misses - m0), 2);

        // invalidate during beat 2 forces a second refill
        a0 = mem_acks;
        cycle(1'b1, 16'h0005, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        n = 4;
        do begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end while (!req_ack && n < 60);
        chk("inv lat", 32'(n), 11);
        chk("inv data", req_data, 32'hA5);
        chk("inv memacks", 32'(mem_acks - a0), 8);
        run_req("inv hit", 16'h0006, 32'hA6, 1);

        // reset during refill, stray acks afterwards
        cycle(1'b1, 16'h0000, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        stray = 1'b1;
        #1;
        chk("rstmid mreq", 32'(mem_req), 0);
        chk("rstmid ack", 32'(req_ack), 0);
        cycle(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("stray mreq", 32'(mem_req), 0);
        chk("stray ack", 32'(req_ack), 0);
        stray = 1'b0;
        a0 = mem_acks;
        run_req("post rst", 16'h0000, 32'hA0, 6);
        chk("post rst memacks", 32'(mem_acks - a0), 4);

        // top line stays inside its line
        cycle(1'b1, 16'hFFFF, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("top miss", 32'(dbg_miss), 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk($sformatf("top maddr %0d", i), 32'(mem_addr),
                32'hFFFC + 32'(i));
        end
        cycle(1'b0, '0, 1'b0);
        chk("top ack", 32'(req_ack), 1);
        chk("top data", req_data, 32'h1009F);
        chk("top nowrap", 32'(mem_addr), 32'hFFFC);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
